vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
Raster timing generator clocked directly by the pixel clock (the divided clock from the pixel clock divider). It runs horizontal and vertical counters for 640x480@60 Hz (800x525 total). From those counters it produces HSYNC/VSYNC for the VGA connector, plus the pixel coordinates, a visible-area flag and line/frame strobes for the Pong renderer and game-logic stages downstream. All outputs are registered and mutually aligned: in any cycle, every output describes the same pixel (x, y).

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, level driven on hsync/vsync during the sync pulse (0 = active-low)
CNT_W, 10, width of the x/y counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk_in  input  1  pixel clock; all logic on its rising edge
rst_n  input  1  synchronous active-low reset
hsync  output  1  horizontal sync to the VGA connector
vsync  output  1  vertical sync to the VGA connector
video_on  output  1  1 when (x, y) is inside the visible area
x  output  CNT_W  current horizontal count, 0..H_TOTAL-1
y  output  CNT_W  current vertical count, 0..V_TOTAL-1
line_tick  output  1  one-cycle pulse when x==0
frame_tick  output  1  one-cycle pulse when x==0 and y==0

Behaviour:
- Interface: one clock (clk_in); reset is synchronous and active-low (rst_n), sampled only on the rising edge of clk_in.
- Derived constants:
  - H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK (800).
  - V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK (525).
- Reset (rst_n==0 at an edge): the block parks at the last pixel of the frame.
  - x = H_TOTAL-1 (799), y = V_TOTAL-1 (524).
  - video_on = 0, line_tick = 0, frame_tick = 0.
  - hsync = vsync = ~SYNC_ACTIVE (inactive).
  - Reset asserted mid-frame takes effect at the next edge; no partial line completes.
- First edge after reset release: x = 0, y = 0, video_on = 1, line_tick = 1, frame_tick = 1. Pixel (0,0) is never skipped.
- Horizontal counter: x increments by 1 every clock.
  - At x == H_TOTAL-1, x wraps to 0.
- Vertical counter: y increments only on the horizontal wrap.
  - At y == V_TOTAL-1 together with the horizontal wrap, y wraps to 0.
- Decode: outputs are computed from the next-state counter values and registered, so they stay cycle-aligned with x/y (zero latency relative to the coordinates).
  - video_on = (x < H_VISIBLE) && (y < V_VISIBLE).
  - hsync = SYNC_ACTIVE when H_VISIBLE+H_FRONT <= x <= H_VISIBLE+H_FRONT+H_SYNC-1 (656..751); otherwise ~SYNC_ACTIVE.
  - vsync = SYNC_ACTIVE when V_VISIBLE+V_FRONT <= y <= V_VISIBLE+V_FRONT+V_SYNC-1 (490..491), for the whole line regardless of x; otherwise ~SYNC_ACTIVE.
  - line_tick = (x == 0); frame_tick = (x == 0 && y == 0).
- Glitch-free: every output is a flop output, with no combinational path from a counter to a port.
- Counters never exceed their totals. Any out-of-range value (not reachable in normal operation) wraps to 0 on the next increment.

Test Plan:
- Reset/release: hold rst_n=0 for 5 clocks -> x=799, y=524, hsync=vsync=1, video_on=0, ticks 0. Release -> next edge x=0, y=0, video_on=1, line_tick=1, frame_tick=1.
- Horizontal timing: run one line -> video_on=1 for exactly 640 clocks (x 0..639). hsync=0 for exactly 96 clocks, first at x=656, last at x=751. line_tick period is 800 clocks.
- Vertical timing: run one full frame -> vsync=0 for exactly 1600 clocks (lines 490..491). frame_tick period is 420000 clocks. video_on=0 for all of y=480..524.
- Wrap: at x=799, y=524 -> next cycle x=0, y=0, frame_tick=1. At x=799, y=10 -> next cycle x=0, y=11, line_tick=1, frame_tick=0.
- Mid-frame reset: assert rst_n=0 for 1 clock at x=300, y=200 -> next cycle x=799, y=524, all outputs at reset values. After release, the frame restarts at (0,0).
- Polarity: SYNC_ACTIVE=1 build -> hsync=1 only at x 656..751, vsync=1 only at y 490..491, and both low during reset.

Source files
------------

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster-timing bundle from the sync generator to the VGA
// pins and the downstream renderer / game-logic stages.
//   hsync, vsync  sync pulses for the connector
//   video_on      (x, y) lies in the visible area
//   x, y          current pixel coordinates
//   line_tick     one-cycle pulse at x == 0
//   frame_tick    one-cycle pulse at x == 0 && y == 0
// master: the timing generator; slave: any consumer.
interface vga_sync_gen_if #(
  parameter int CNT_W = 10
);
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             line_tick;
  logic             frame_tick;

  modport master (output hsync, vsync, video_on, x, y, line_tick, frame_tick);
  modport slave  (input  hsync, vsync, video_on, x, y, line_tick, frame_tick);
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator running on the pixel clock.
// Horizontal/vertical counters sweep the full 800x525 raster (default
// 640x480@60) and drive sync pulses, coordinates, a visible-area flag and
// line/frame strobes. Every output is a flop and all of them describe the
// same pixel in any given cycle.
// Ports:
//   clk_in  pixel clock, rising edge
//   rst_n   synchronous active-low reset; parks at the last pixel of a frame
//   vga     vga_sync_gen_if.master carrying hsync/vsync/video_on/x/y/ticks
module vga_sync_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int CNT_W       = 10
) (
  input  logic           clk_in,
  input  logic           rst_n,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Counter-width copies of the timing points so every compare is same-width.
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    logic line_tick;
    logic frame_tick;
  } flags_t;

  // Flag values while parked in reset: nothing visible, syncs idle.
  localparam flags_t FLAGS_RST = '{
    hsync:      ~SYNC_ACTIVE,
    vsync:      ~SYNC_ACTIVE,
    video_on:   1'b0,
    line_tick:  1'b0,
    frame_tick: 1'b0
  };

  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  flags_t           flags_q, flags_d;
  logic             h_wrap;
  logic             hs_win;
  logic             vs_win;

  // Next-state counters. '>=' rather than '==' so an out-of-range value
  // (never reached in normal operation) still wraps back to 0.
  always_comb begin
    h_wrap = (x_q >= H_LAST);
    x_d    = h_wrap ? '0 : x_q + CNT_W'(1);
    y_d    = y_q;
    if (h_wrap) begin
      y_d = (y_q >= V_LAST) ? '0 : y_q + CNT_W'(1);
    end
  end

  // Decode from the next-state counters so the registered flags land in the
  // same cycle as the registered coordinates they describe.
  always_comb begin
    hs_win             = (x_d >= HS_FIRST) && (x_d <= HS_LAST);
    vs_win             = (y_d >= VS_FIRST) && (y_d <= VS_LAST);
    flags_d            = FLAGS_RST;
    flags_d.video_on   = (x_d < H_VIS) && (y_d < V_VIS);
    flags_d.hsync      = hs_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    flags_d.vsync      = vs_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    flags_d.line_tick  = (x_d == '0);
    flags_d.frame_tick = (x_d == '0) && (y_d == '0);
  end

  // Reset parks on the last pixel so the first free-running edge lands on
  // (0,0) and raises both ticks.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      x_q     <= H_LAST;
      y_q     <= V_LAST;
      flags_q <= FLAGS_RST;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      flags_q <= flags_d;
    end
  end

  assign vga.x          = x_q;
  assign vga.y          = y_q;
  assign vga.hsync      = flags_q.hsync;
  assign vga.vsync      = flags_q.vsync;
  assign vga.video_on   = flags_q.video_on;
  assign vga.line_tick  = flags_q.line_tick;
  assign vga.frame_tick = flags_q.frame_tick;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. Three builds run side by side on one clock/reset:
//   dut_a  default 640x480@60 timing, active-low syncs
//   dut_b  default horizontal timing, shortened vertical (15 lines)
//   dut_c  same as dut_b with active-high syncs
// A per-cycle scoreboard derives every expected output from an absolute
// pixel index (n mod frame size) and compares all three builds each cycle;
// the test tasks add targeted timing checks on top.
module tb_vga_sync_gen;

  localparam int HT   = 800;
  localparam int VT_A = 525;
  localparam int VV_S = 8;
  localparam int VF_S = 2;
  localparam int VS_S = 2;
  localparam int VB_S = 3;
  localparam int VT_S = VV_S + VF_S + VS_S + VB_S;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] x;
    logic [9:0] y;
    logic       lt;
    logic       ft;
  } obs_t;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_no  = 0;
  int   na = -1, nb = -1, nc = -1;
  obs_t qa[$], qb[$], qc[$];
  obs_t oa, ob, oc;

  always #5 clk_in = ~clk_in;

  vga_sync_gen_if #(.CNT_W(10)) if_a ();
  vga_sync_gen_if #(.CNT_W(10)) if_b ();
  vga_sync_gen_if #(.CNT_W(10)) if_c ();

  vga_sync_gen dut_a (.clk_in(clk_in), .rst_n(rst_n), .vga(if_a));

  vga_sync_gen #(.V_VISIBLE(VV_S), .V_FRONT(VF_S), .V_SYNC(VS_S), .V_BACK(VB_S))
    dut_b (.clk_in(clk_in), .rst_n(rst_n), .vga(if_b));

  vga_sync_gen #(.V_VISIBLE(VV_S), .V_FRONT(VF_S), .V_SYNC(VS_S), .V_BACK(VB_S),
                 .SYNC_ACTIVE(1'b1))
    dut_c (.clk_in(clk_in), .rst_n(rst_n), .vga(if_c));

  assign oa = {if_a.hsync, if_a.vsync, if_a.video_on, if_a.x, if_a.y, if_a.line_tick, if_a.frame_tick};
  assign ob = {if_b.hsync, if_b.vsync, if_b.video_on, if_b.x, if_b.y, if_b.line_tick, if_b.frame_tick};
  assign oc = {if_c.hsync, if_c.vsync, if_c.video_on, if_c.x, if_c.y, if_c.line_tick, if_c.frame_tick};

  // Expected outputs for pixel index n (n < 0: parked in reset).
  function automatic obs_t model(int n, int vv, int vf, int vs, int vt, logic sa);
    obs_t o;
    int   xx, yy;
    if (n < 0) begin
      xx = HT - 1;
      yy = vt - 1;
    end else begin
      xx = n % HT;
      yy = (n / HT) % vt;
    end
    o.x   = xx[9:0];
    o.y   = yy[9:0];
    o.von = (n >= 0) && (xx < 640) && (yy < vv);
    o.hs  = (n >= 0 && xx >= 656 && xx <= 751) ? sa : ~sa;
    o.vs  = (n >= 0 && yy >= vv + vf && yy <= vv + vf + vs - 1) ? sa : ~sa;
    o.lt  = (n >= 0) && (xx == 0);
    o.ft  = (n >= 0) && (xx == 0) && (yy == 0);
    return o;
  endfunction

  // One clock: push the expected pixel at the edge, pop and score it half a
  // cycle later once the DUT flops have settled.
  task automatic clock_and_score();
    obs_t ea, eb, ec;
    @(posedge clk_in);
    na = rst_n ? (na + 1) % (HT * VT_A) : -1;
    nb = rst_n ? (nb + 1) % (HT * VT_S) : -1;
    nc = rst_n ? (nc + 1) % (HT * VT_S) : -1;
    qa.push_back(model(na, 480, 10, 2, VT_A, 1'b0));
    qb.push_back(model(nb, VV_S, VF_S, VS_S, VT_S, 1'b0));
    qc.push_back(model(nc, VV_S, VF_S, VS_S, VT_S, 1'b1));
    @(negedge clk_in);
    cyc_no++;
    ea = qa.pop_front();
    eb = qb.pop_front();
    ec = qc.pop_front();
    n_tests += 3;
    if (oa !== ea) begin
      n_fail++;
      if (n_fail < 30) $display("FAIL sb_a cyc=%0d got=%h exp=%h", cyc_no, oa, ea);
    end
    if (ob !== eb) begin
      n_fail++;
      if (n_fail < 30) $display("FAIL sb_b cyc=%0d got=%h exp=%h", cyc_no, ob, eb);
    end
    if (oc !== ec) begin
      n_fail++;
      if (n_fail < 30) $display("FAIL sb_c cyc=%0d got=%h exp=%h", cyc_no, oc, ec);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) clock_and_score();
    n_tests++;
    if (if_a.x !== 10'd799 || if_a.y !== 10'd524) begin
      n_fail++; $display("FAIL rst_xy got=%0d,%0d exp=799,524", if_a.x, if_a.y);
    end
    n_tests++;
    if ({if_a.hsync, if_a.vsync} !== 2'b11) begin
      n_fail++; $display("FAIL rst_sync_lo got=%b exp=11", {if_a.hsync, if_a.vsync});
    end
    n_tests++;
    if ({if_a.video_on, if_a.line_tick, if_a.frame_tick} !== 3'b000) begin
      n_fail++; $display("FAIL rst_flags got=%b exp=000", {if_a.video_on, if_a.line_tick, if_a.frame_tick});
    end
    n_tests++;
    if (if_b.y !== 10'd14) begin
      n_fail++; $display("FAIL rst_y_short got=%0d exp=14", if_b.y);
    end
    n_tests++;
    if ({if_c.hsync, if_c.vsync} !== 2'b00) begin
      n_fail++; $display("FAIL rst_sync_hi got=%b exp=00", {if_c.hsync, if_c.vsync});
    end
    rst_n = 1'b1;
    clock_and_score();
    n_tests++;
    if (if_a.x !== 10'd0 || if_a.y !== 10'd0) begin
      n_fail++; $display("FAIL rel_xy got=%0d,%0d exp=0,0", if_a.x, if_a.y);
    end
    n_tests++;
    if ({if_a.video_on, if_a.line_tick, if_a.frame_tick} !== 3'b111) begin
      n_fail++; $display("FAIL rel_flags got=%b exp=111", {if_a.video_on, if_a.line_tick, if_a.frame_tick});
    end
  endtask

  task automatic test_horizontal();
    int von_cnt = 0, hs_cnt = 0, first = -1, last = -1, gap = 0;
    for (int i = 0; i < HT; i++) begin
      if (if_a.video_on === 1'b1) von_cnt++;
      if (if_a.hsync === 1'b0) begin
        hs_cnt++;
        if (first < 0) first = int'(if_a.x);
        last = int'(if_a.x);
      end
      clock_and_score();
    end
    n_tests++;
    if (von_cnt != 640) begin n_fail++; $display("FAIL h_video got=%0d exp=640", von_cnt); end
    n_tests++;
    if (hs_cnt != 96) begin n_fail++; $display("FAIL h_sync_len got=%0d exp=96", hs_cnt); end
    n_tests++;
    if (first != 656 || last != 751) begin
      n_fail++; $display("FAIL h_sync_pos got=%0d..%0d exp=656..751", first, last);
    end
    do begin
      clock_and_score();
      gap++;
    end while (if_a.line_tick !== 1'b1 && gap < 2000);
    n_tests++;
    if (gap != HT) begin n_fail++; $display("FAIL line_period got=%0d exp=800", gap); end
  endtask

  task automatic test_wrap_line();
    int k = 0;
    while (!(if_a.x === 10'd799 && if_a.y === 10'd10) && k < 20000) begin
      clock_and_score();
      k++;
    end
    n_tests++;
    if (k >= 20000) begin n_fail++; $display("FAIL wrap_line_wait got=timeout exp=x799,y10"); end
    clock_and_score();
    n_tests++;
    if (if_a.x !== 10'd0 || if_a.y !== 10'd11) begin
      n_fail++; $display("FAIL wrap_line_xy got=%0d,%0d exp=0,11", if_a.x, if_a.y);
    end
    n_tests++;
    if ({if_a.line_tick, if_a.frame_tick} !== 2'b10) begin
      n_fail++; $display("FAIL wrap_line_ticks got=%b exp=10", {if_a.line_tick, if_a.frame_tick});
    end
  endtask

  task automatic test_vertical();
    int k = 0, vs_lo = 0, von_bot = 0, ft_cnt = 0, vmin = 999, vmax = -1;
    int c_hs = 0, c_vs = 0, c_bad = 0;
    while (if_b.frame_tick !== 1'b1 && k < 13000) begin
      clock_and_score();
      k++;
    end
    n_tests++;
    if (k >= 13000) begin n_fail++; $display("FAIL frame_wait got=timeout exp=frame_tick"); end
    for (int i = 0; i < HT * VT_S; i++) begin
      if (if_b.frame_tick === 1'b1) ft_cnt++;
      if (if_b.vsync === 1'b0) begin
        vs_lo++;
        if (int'(if_b.y) < vmin) vmin = int'(if_b.y);
        if (int'(if_b.y) > vmax) vmax = int'(if_b.y);
      end
      if (if_b.video_on !== 1'b0 && if_b.y >= 10'd8) von_bot++;
      if (if_c.hsync === 1'b1) c_hs++;
      if (if_c.vsync === 1'b1) c_vs++;
      if (if_c.hsync === 1'b1 && (if_c.x < 10'd656 || if_c.x > 10'd751)) c_bad++;
      if (if_c.vsync === 1'b1 && (if_c.y < 10'd10 || if_c.y > 10'd11)) c_bad++;
      clock_and_score();
    end
    n_tests++;
    if (vs_lo != 1600) begin n_fail++; $display("FAIL v_sync_len got=%0d exp=1600", vs_lo); end
    n_tests++;
    if (vmin != 10 || vmax != 11) begin
      n_fail++; $display("FAIL v_sync_lines got=%0d..%0d exp=10..11", vmin, vmax);
    end
    n_tests++;
    if (von_bot != 0) begin n_fail++; $display("FAIL v_blank_video got=%0d exp=0", von_bot); end
    n_tests++;
    if (ft_cnt != 1 || if_b.frame_tick !== 1'b1) begin
      n_fail++; $display("FAIL frame_period got=%0d,%b exp=1,1", ft_cnt, if_b.frame_tick);
    end
    n_tests++;
    if (c_hs != 96 * VT_S || c_vs != 1600) begin
      n_fail++; $display("FAIL pol_counts got=%0d,%0d exp=1440,1600", c_hs, c_vs);
    end
    n_tests++;
    if (c_bad != 0) begin n_fail++; $display("FAIL pol_window got=%0d exp=0", c_bad); end
  endtask

  task automatic test_wrap_frame();
    int k = 0;
    while (!(if_b.x === 10'd799 && if_b.y === 10'd14) && k < 13000) begin
      clock_and_score();
      k++;
    end
    n_tests++;
    if (k >= 13000) begin n_fail++; $display("FAIL wrap_frame_wait got=timeout exp=x799,y14"); end
    clock_and_score();
    n_tests++;
    if (if_b.x !== 10'd0 || if_b.y !== 10'd0) begin
      n_fail++; $display("FAIL wrap_frame_xy got=%0d,%0d exp=0,0", if_b.x, if_b.y);
    end
    n_tests++;
    if ({if_b.line_tick, if_b.frame_tick} !== 2'b11) begin
      n_fail++; $display("FAIL wrap_frame_ticks got=%b exp=11", {if_b.line_tick, if_b.frame_tick});
    end
  endtask

  task automatic test_mid_reset();
    int k = 0;
    while (!(if_b.x === 10'd300 && if_b.y === 10'd3) && k < 13000) begin
      clock_and_score();
      k++;
    end
    n_tests++;
    if (k >= 13000) begin n_fail++; $display("FAIL mid_wait got=timeout exp=x300,y3"); end
    rst_n = 1'b0;
    clock_and_score();
    n_tests++;
    if (if_b.x !== 10'd799 || if_b.y !== 10'd14) begin
      n_fail++; $display("FAIL mid_rst_xy got=%0d,%0d exp=799,14", if_b.x, if_b.y);
    end
    n_tests++;
    if ({if_b.hsync, if_b.vsync, if_b.video_on, if_b.line_tick, if_b.frame_tick} !== 5'b11000) begin
      n_fail++; $display("FAIL mid_rst_flags got=%b exp=11000",
                         {if_b.hsync, if_b.vsync, if_b.video_on, if_b.line_tick, if_b.frame_tick});
    end
    n_tests++;
    if (if_a.x !== 10'd799 || if_a.y !== 10'd524) begin
      n_fail++; $display("FAIL mid_rst_full got=%0d,%0d exp=799,524", if_a.x, if_a.y);
    end
    rst_n = 1'b1;
    clock_and_score();
    n_tests++;
    if (if_b.x !== 10'd0 || if_b.y !== 10'd0 || if_b.frame_tick !== 1'b1) begin
      n_fail++; $display("FAIL mid_restart got=%0d,%0d,%b exp=0,0,1", if_b.x, if_b.y, if_b.frame_tick);
    end
    repeat (20) clock_and_score();
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_wrap_line();
    test_vertical();
    test_wrap_frame();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
